// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART transmit definitions: frame constants and the
//                word / byte state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 87;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } word_state_t;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_DATA  = 2'd2,
        B_STOP  = 2'd3
    } byte_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 byte serialiser. A start request arriving in the final
//                cycle of a stop bit chains the next frame with no idle gap.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx_serial,
    output logic       o_byte_done
);

    localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_pre  = c_cnt_w'(CLKS_PER_BIT - 2);
    localparam logic [2:0]         c_bit_last = 3'(UART_DATA_BITS - 1);

    byte_state_t        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_bit_end;

    assign w_bit_end = (r_cnt == c_cnt_last);

    // Frame sequencer: start, 8 data bits LSB first, stop; line and done registered.
    // byte_done is raised during the last stop cycle so the requester can
    // present the next byte in time for a back-to-back start bit.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= B_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            o_tx_serial <= 1'b1;
            o_byte_done <= 1'b0;
        end else begin
            o_byte_done <= 1'b0;
            case (r_state)
                B_IDLE: begin
                    o_tx_serial <= 1'b1;
                    r_cnt       <= '0;
                    if (i_start) begin
                        r_state     <= B_START;
                        r_shift     <= i_byte;
                        r_bit_idx   <= '0;
                        o_tx_serial <= 1'b0;
                    end
                end
                B_START: begin
                    if (w_bit_end) begin
                        r_cnt       <= '0;
                        r_state     <= B_DATA;
                        o_tx_serial <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                B_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == c_bit_last) begin
                            r_state     <= B_STOP;
                            o_tx_serial <= 1'b1;
                        end else begin
                            r_bit_idx   <= r_bit_idx + 1'b1;
                            r_shift     <= r_shift >> 1;
                            o_tx_serial <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                B_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (i_start) begin
                            r_state     <= B_START;
                            r_shift     <= i_byte;
                            r_bit_idx   <= '0;
                            o_tx_serial <= 1'b0;
                        end else begin
                            r_state <= B_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_cnt_pre) begin
                            o_byte_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= B_IDLE;
                    o_tx_serial <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_tx
//  Description : Accepts one WORD_W-bit word over valid/ready and streams it
//                as WORD_W/8 back-to-back 8N1 frames, least significant
//                byte first.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int WORD_W       = 256
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_tx_serial,
    output logic              o_busy,
    output logic              o_done
);

    localparam int                 c_num_bytes = WORD_W / UART_DATA_BITS;
    localparam int                 c_idx_w     = (c_num_bytes > 1) ? $clog2(c_num_bytes) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(c_num_bytes - 1);

    word_state_t        r_state;
    logic [WORD_W-1:0]  r_word;
    logic [c_idx_w-1:0] r_byte_idx;
    logic               r_start_pend;

    logic               w_byte_done;
    logic               w_advance;
    logic               w_start;
    logic [7:0]         w_next_byte;
    logic [7:0]         w_byte;

    generate
        if (c_num_bytes > 1) begin : g_multi_byte
            assign w_next_byte = r_word[15:8];
        end else begin : g_single_byte
            assign w_next_byte = r_word[7:0];
        end
    endgenerate

    // Chaining happens in the same cycle byte_done is seen, so the next byte
    // is taken from the not-yet-shifted register's second byte.
    assign w_advance = (r_state == SEND) && w_byte_done && (r_byte_idx != c_idx_last);
    assign w_start   = r_start_pend | w_advance;
    assign w_byte    = w_advance ? w_next_byte : r_word[7:0];

    // Word sequencer: capture on handshake, step through bytes, pulse done.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_byte_idx   <= '0;
            r_start_pend <= 1'b0;
            o_ready      <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            r_start_pend <= 1'b0;
            o_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_word       <= i_data;
                        r_byte_idx   <= '0;
                        r_start_pend <= 1'b1;
                        r_state      <= SEND;
                        o_ready      <= 1'b0;
                        o_busy       <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_byte_done) begin
                        if (r_byte_idx == c_idx_last) begin
                            r_state <= DONE;
                            o_done  <= 1'b1;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_word     <= r_word >> UART_DATA_BITS;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_start     (w_start),
        .i_byte      (w_byte),
        .o_tx_serial (o_tx_serial),
        .o_byte_done (w_byte_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_word_tx
//  Description : Self-checking bench for uart_word_tx with a cycle-level
//                reference model and a mid-bit UART decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_word_tx;

    localparam int CPB    = 4;
    localparam int WORD_W = 256;
    localparam int NBYTES = WORD_W / 8;
    localparam int WORD_CYC = NBYTES * 10 * CPB;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              valid = 1'b0;
    logic [WORD_W-1:0] data = '0;
    logic              ready, tx, busy, done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model state
    logic              m_active = 1'b0;
    int                m_t = 0;
    logic [WORD_W-1:0] m_word = '0;
    int                hs_cyc = 0;
    int                hs_count = 0;
    logic              cmp_en = 1'b0;

    // decoder output
    logic [7:0] byte_q[$];
    int         start_q[$];

    uart_word_tx #(
        .CLKS_PER_BIT (CPB),
        .WORD_W       (WORD_W)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_valid     (valid),
        .i_data      (data),
        .o_ready     (ready),
        .o_tx_serial (tx),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Line level implied by the 8N1 frame sequence: k cycles after the first start bit.
    function automatic logic exp_tx();
        int k, b, p;
        k = m_t - 1;
        if (!m_active || k < 0 || k >= WORD_CYC) return 1'b1;
        b = k / (10 * CPB);
        p = (k % (10 * CPB)) / CPB;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return m_word[b*8 + p - 1];
    endfunction

    // Model: a word occupies the block from the handshake edge until two edges
    // after its last stop bit; the line is derived from elapsed time only.
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_active = 1'b0;
                m_t      = 0;
            end else if (m_active) begin
                m_t = m_t + 1;
                if (m_t >= WORD_CYC + 2) m_active = 1'b0;
            end else if (valid) begin
                m_active = 1'b1;
                m_t      = 0;
                m_word   = data;
                hs_cyc   = cyc + 1;
                hs_count = hs_count + 1;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("tx", int'(tx), int'(exp_tx()));
                chk("busy", int'(busy), int'(m_active));
                chk("ready", int'(ready), int'(!m_active));
                chk("done", int'(done), int'(m_active && m_t == WORD_CYC + 1));
            end
        end
    end

    // Mid-bit UART decoder working from the line alone.
    initial begin
        int         t0, d;
        logic       mb;
        logic [7:0] b;
        mb = 1'b0; t0 = 0; d = 0; b = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mb = 1'b0;
            end else if (!mb) begin
                if (tx === 1'b0) begin
                    mb = 1'b1;
                    t0 = cyc;
                    start_q.push_back(cyc);
                end
            end else begin
                d = cyc - t0;
                if (d == CPB / 2) begin
                    chk("mon_start_bit", int'(tx), 0);
                end else if (d == CPB / 2 + 9 * CPB) begin
                    chk("mon_stop_bit", int'(tx), 1);
                    byte_q.push_back(b);
                    mb = 1'b0;
                end else if (d > CPB / 2 && ((d - CPB / 2) % CPB) == 0) begin
                    b[(d - CPB / 2) / CPB - 1] = tx;
                end
            end
        end
    end

    task automatic send(input logic [WORD_W-1:0] w);
        int h0, n;
        h0 = hs_count;
        n  = 0;
        @(negedge clk);
        valid = 1'b1;
        data  = w;
        while (hs_count == h0 && n < 3 * WORD_CYC) begin
            @(negedge clk);
            n++;
        end
        if (hs_count == h0) chk("handshake_timeout", 0, 1);
        valid = 1'b0;
        data  = rand_word();
    endtask

    task automatic wait_done(output int dc);
        int n;
        n  = 0;
        dc = -1;
        while (done !== 1'b1 && n < WORD_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        if (done === 1'b1) dc = cyc;
        else chk("done_timeout", 0, 1);
    endtask

    task automatic check_word(input string name, input logic [WORD_W-1:0] w);
        logic [7:0] got;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_q.size() == 0) begin
                chk({name, "_missing_byte"}, i, NBYTES);
                return;
            end
            got = byte_q.pop_front();
            chk(name, int'(got), int'(w[i*8 +: 8]));
        end
    endtask

    initial begin
        logic [WORD_W-1:0] w1, w2;
        int dc, h0, n, hs2;

        // 1: reset and quiet line
        repeat (5) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rstn   = 1'b1;
        cmp_en = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_quiet", start_q.size(), 0);

        // 2: constant A5 word, done latency
        w1 = {NBYTES{8'hA5}};
        send(w1);
        wait_done(dc);
        chk("done_latency", dc - hs_cyc, 1 + 1280);
        repeat (4) @(negedge clk);
        check_word("a5_byte", w1);
        start_q.delete();

        // 3: incrementing bytes, start spacing
        for (int k = 0; k < NBYTES; k++) w1[k*8 +: 8] = 8'(k);
        send(w1);
        wait_done(dc);
        repeat (4) @(negedge clk);
        check_word("inc_byte", w1);
        if (start_q.size() == NBYTES) begin
            chk("first_start", start_q[0] - hs_cyc, 1);
            for (int i = 0; i < NBYTES - 1; i++)
                chk("start_spacing", start_q[i+1] - start_q[i], 40);
        end else begin
            chk("inc_start_count", start_q.size(), NBYTES);
        end
        start_q.delete();

        // 4: valid held with changing data; second word taken after done
        w1 = rand_word();
        w2 = rand_word();
        h0 = hs_count;
        @(negedge clk);
        valid = 1'b1;
        data  = w1;
        n = 0;
        while (hs_count == h0 && n < 100) begin @(negedge clk); n++; end
        chk("b2b_first_hs", hs_count - h0, 1);
        n = 0;
        while (done !== 1'b1 && n < WORD_CYC + 100) begin
            data = rand_word();
            @(negedge clk);
            n++;
        end
        dc   = cyc;
        data = w2;
        n = 0;
        while (hs_count < h0 + 2 && n < 20) begin @(negedge clk); n++; end
        hs2   = hs_cyc;
        valid = 1'b0;
        chk("b2b_accept", hs2 - dc, 2);
        wait_done(dc);
        repeat (4) @(negedge clk);
        check_word("b2b_w1", w1);
        check_word("b2b_w2", w2);
        if (start_q.size() == 2 * NBYTES)
            chk("b2b_gap", start_q[NBYTES] - start_q[NBYTES-1], 43);
        else
            chk("b2b_start_count", start_q.size(), 2 * NBYTES);
        start_q.delete();

        // 5: reset in the middle of byte 5
        w1 = rand_word();
        send(w1);
        n = 0;
        while (byte_q.size() < 5 && n < WORD_CYC) begin @(negedge clk); n++; end
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        for (int i = 0; i < 5; i++) begin
            if (byte_q.size() > 0) chk("pre_rst_byte", int'(byte_q.pop_front()), int'(w1[i*8 +: 8]));
            else chk("pre_rst_byte_missing", i, 5);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        byte_q.delete();
        start_q.delete();
        repeat (20) @(negedge clk);
        chk("post_rst_quiet", start_q.size(), 0);
        w1 = '1;
        send(w1);
        wait_done(dc);
        repeat (4) @(negedge clk);
        check_word("ones_byte", w1);

        // 6: all-zero word, then random words
        w1 = '0;
        send(w1);
        wait_done(dc);
        repeat (4) @(negedge clk);
        check_word("zero_byte", w1);
        for (int r = 0; r < 2; r++) begin
            w1 = rand_word();
            send(w1);
            wait_done(dc);
            repeat (4) @(negedge clk);
            check_word("rand_byte", w1);
        end

        repeat (10) @(negedge clk);
        chk("no_stray_bytes", byte_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
